ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte to the keyboard
//  (e.g. 0xED set-LEDs, 0xFF reset) over the shared kbdclk/kbddat open-drain lines.

---
 rtl/ps2_host_tx_pkg.sv | 17 +
 rtl/ps2_line_sync.sv | 20 ++
 rtl/ps2_host_tx.sv | 126 ++++++++++++
 tb/tb_ps2_host_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 host-transmit state encodings, command codes and parity helper.
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_WAIT_IDLE,
    ST_ERROR
  } state_t;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchroniser for a PS/2 pad plus one-cycle falling-edge pulse.
//  clk, rst_n : system clock, async active-low reset
//  i_pad      : raw pad value (async)
//  o_level    : synchronised level
//  o_fall     : one-cycle pulse on synchronised 1->0
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pad,
  output logic o_level,
  output logic o_fall
);
  logic [2:0] r_sh;
  // Reset to the idle-high line level so no spurious edge follows reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sh <= '1;
    else r_sh <= {r_sh[1:0], i_pad};
  assign o_level = r_sh[1];
  assign o_fall  = r_sh[2] & ~r_sh[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, RTS, device-clocked frame, ACK, timeout).
//  clk, rst_n           : system clock, async active-low reset
//  tx_data, tx_valid    : command byte and request, accepted when tx_valid && tx_ready
//  tx_ready, busy       : idle / in-progress status
//  tx_done, tx_err      : one-cycle completion pulses (ACKed / NACK or timeout)
//  kbdclk_in, kbddat_in : PS/2 pad values (async)
//  kbdclk_oe, kbddat_oe : 1 pulls the open-drain line low
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int INHIBIT_US = 100,
  parameter int RTS_CYCLES = 16,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       kbdclk_in,
  input  logic       kbddat_in,
  output logic       kbdclk_oe,
  output logic       kbddat_oe
);
  localparam int INH_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TO_CYC  = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int CNT_MAX = INH_CYC > RTS_CYCLES ? INH_CYC : RTS_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(TO_CYC + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_to;
  logic [3:0]       r_e;
  logic [7:0]       r_byte;
  logic             r_par, r_clk_oe, r_dat_oe, r_done, r_err;
  logic             w_clk, w_dat, w_fall, w_dat_fall_unused;
  logic [3:0]       w_e_nx;
  ps2_line_sync u_clk_sync (.clk(clk), .rst_n(rst_n), .i_pad(kbdclk_in), .o_level(w_clk), .o_fall(w_fall));
  ps2_line_sync u_dat_sync (.clk(clk), .rst_n(rst_n), .i_pad(kbddat_in), .o_level(w_dat), .o_fall(w_dat_fall_unused));
  assign w_e_nx = r_e + 4'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_to     <= '0;
      r_e      <= '0;
      r_byte   <= '0;
      r_par    <= 1'b0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (tx_valid) begin
            r_byte   <= tx_data;
            r_par    <= odd_parity(tx_data);
            r_cnt    <= '0;
            r_clk_oe <= 1'b1;
            r_dat_oe <= 1'b0;
            r_state  <= ST_INHIBIT;
          end
        ST_INHIBIT:
          if (r_cnt == INH_LAST) begin
            r_cnt    <= '0;
            r_dat_oe <= 1'b1;
            r_state  <= ST_RTS;
          end else r_cnt <= r_cnt + 1'b1;
        ST_RTS:
          if (r_cnt == RTS_LAST) begin
            r_clk_oe <= 1'b0;
            r_e      <= '0;
            r_to     <= '0;
            r_state  <= ST_SEND;
          end else r_cnt <= r_cnt + 1'b1;
        ST_SEND: begin
          r_to <= r_to + 1'b1;
          // Timeout is checked first so it wins over a coincident clock fall.
          if (r_to == TO_LAST) begin
            r_dat_oe <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= ST_ERROR;
          end else if (w_fall) begin
            r_e      <= w_e_nx;
            r_dat_oe <= w_e_nx <= 4'd8 ? ~r_byte[r_e[2:0]] : w_e_nx == 4'd9 ? ~r_par : 1'b0;
            if (w_e_nx == 4'd11) begin
              r_err   <= w_dat;
              r_state <= w_dat ? ST_ERROR : ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          r_to <= r_to + 1'b1;
          if (r_to == TO_LAST) begin
            r_err   <= 1'b1;
            r_state <= ST_ERROR;
          end else if (w_clk && w_dat) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_ERROR: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  assign tx_ready  = r_state == ST_IDLE;
  assign busy      = r_state != ST_IDLE;
  assign tx_done   = r_done;
  assign tx_err    = r_err;
  assign kbdclk_oe = r_clk_oe;
  assign kbddat_oe = r_dat_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed self-checking bench for ps2_host_tx with a 10 kHz PS/2 device model.
module tb_ps2_host_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_err, kbdclk_oe, kbddat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       kbdclk_in, kbddat_in;
  int         n_chk = 0, n_pass = 0;
  int         n_done = 0, n_err = 0, n_both = 0, n_inh = 0, n_ovl = 0;

  assign kbdclk_in = dev_clk & ~kbdclk_oe;
  assign kbddat_in = dev_dat & ~kbddat_oe;

  ps2_host_tx #(.CLK_HZ(1_000_000), .INHIBIT_US(100), .RTS_CYCLES(16), .TIMEOUT_MS(15)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_err(tx_err),
    .kbdclk_in(kbdclk_in), .kbddat_in(kbddat_in), .kbdclk_oe(kbdclk_oe), .kbddat_oe(kbddat_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_done) n_done++;
    if (tx_err) n_err++;
    if (tx_done && tx_err) n_both++;
    if (kbdclk_oe && !kbddat_oe) n_inh++;
    if (kbdclk_oe && kbddat_oe) n_ovl++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("accept", busy, 1);
  endtask

  task automatic device_frame(input logic ack, output logic [10:0] fr);
    int n = 0;
    fr = '0;
    while (kbdclk_oe && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (kbdclk_oe) begin
      chk("clk_release", kbdclk_oe, 0);
      return;
    end
    cyc(20);
    fr[0] = kbddat_in;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      cyc(50);
      dev_clk = 1'b1;
      cyc(50);
      fr[k] = kbddat_in;
    end
    dev_dat = ack;
    cyc(25);
    dev_clk = 1'b0;
    cyc(50);
    dev_clk = 1'b1;
    cyc(25);
    dev_dat = 1'b1;
  endtask

  task automatic frame_test(input string tag, input logic [7:0] b, input logic par);
    logic [10:0] fr;
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    send(b);
    device_frame(1'b0, fr);
    cyc(10);
    chk({tag, "_frame"}, 32'(fr), 32'({1'b1, par, b, 1'b0}));
    chk({tag, "_done"}, n_done - d0, 1);
    chk({tag, "_err"}, n_err - e0, 0);
    chk({tag, "_ready"}, tx_ready, 1);
    chk({tag, "_lines"}, {kbdclk_oe, kbddat_oe}, 0);
  endtask

  initial begin
    logic [10:0] fr, fr2;
    int n, d0, e0, i0, o0, nlow;
    logic got_done;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_lines", {kbdclk_oe, kbddat_oe}, 0);
    chk("rst_pulses", {tx_done, tx_err}, 0);

    i0 = n_inh;
    o0 = n_ovl;
    frame_test("ed", 8'hED, 1'b1);
    chk("ed_inhibit_cyc", n_inh - i0, 100);
    chk("ed_rts_cyc", n_ovl - o0, 16);

    frame_test("x00", 8'h00, 1'b1);
    frame_test("x01", 8'h01, 1'b0);

    d0 = n_done;
    e0 = n_err;
    send(8'hED);
    fork
      device_frame(1'b1, fr);
      begin
        n = 0;
        while (!tx_err && n < 3000) begin
          @(negedge clk);
          n++;
        end
        chk("nack_err", tx_err, 1);
        chk("nack_lines", {kbdclk_oe, kbddat_oe}, 0);
        @(negedge clk);
        chk("nack_ready", tx_ready, 1);
        chk("nack_err_width", tx_err, 0);
      end
    join
    cyc(10);
    chk("nack_frame", 32'(fr), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    chk("nack_err_cnt", n_err - e0, 1);
    chk("nack_done_cnt", n_done - d0, 0);

    e0 = n_err;
    send(8'hED);
    n = 0;
    while (kbdclk_oe && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!tx_err && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, 15000);
    chk("to_lines", {kbdclk_oe, kbddat_oe}, 0);
    @(negedge clk);
    chk("to_ready", tx_ready, 1);
    chk("to_err_cnt", n_err - e0, 1);

    send(8'h00);
    n = 0;
    while (kbdclk_oe && n < 1000) begin
      @(negedge clk);
      n++;
    end
    cyc(20);
    for (int k = 1; k <= 4; k++) begin
      dev_clk = 1'b0;
      cyc(50);
      dev_clk = 1'b1;
      cyc(50);
    end
    dev_clk = 1'b0;
    cyc(10);
    chk("pre_rst_dat_oe", kbddat_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_lines", {kbdclk_oe, kbddat_oe}, 0);
    @(negedge clk);
    dev_clk = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_ready", tx_ready, 1);
    frame_test("ff", 8'hFF, 1'b1);

    d0 = n_done;
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hED;
    chk("hold_busy", busy, 1);
    nlow = 0;
    got_done = 1'b0;
    fork
      device_frame(1'b0, fr);
      begin
        n = 0;
        while (n < 3000) begin
          @(negedge clk);
          if (tx_done) begin
            got_done = 1'b1;
            break;
          end
          if (!busy) nlow++;
          n++;
        end
      end
    join
    chk("hold_first_done", got_done, 1);
    chk("hold_busy_gaps", nlow, 0);
    chk("hold_frame1", 32'(fr), 32'({1'b1, 1'b0, 8'h01, 1'b0}));
    @(negedge clk);
    chk("hold_second_start", busy, 1);
    tx_valid = 1'b0;
    device_frame(1'b0, fr2);
    cyc(10);
    chk("hold_frame2", 32'(fr2), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    chk("hold_done_cnt", n_done - d0, 2);
    chk("done_err_overlap", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
